// File: rtl/core_sequencer_pkg.sv
// Shared encodings for the mincore multicycle sequencer: ALU selectors/modes,
// RV32I opcodes, PC source and writeback selects, and the instruction classes.
package core_sequencer_pkg;
    localparam int ALU_INPUT_SEL_W = 4;

    localparam logic [ALU_INPUT_SEL_W-1:0] ALU_INPUT_SEL_ZERO  = 4'd0;
    localparam logic [ALU_INPUT_SEL_W-1:0] ALU_INPUT_SEL_REG   = 4'd1;
    localparam logic [ALU_INPUT_SEL_W-1:0] ALU_INPUT_SEL_PC    = 4'd2;
    localparam logic [ALU_INPUT_SEL_W-1:0] ALU_INPUT_SEL_IMM_I = 4'd3;
    localparam logic [ALU_INPUT_SEL_W-1:0] ALU_INPUT_SEL_IMM_U = 4'd4;
    localparam logic [ALU_INPUT_SEL_W-1:0] ALU_INPUT_SEL_IMM_S = 4'd5;
    localparam logic [ALU_INPUT_SEL_W-1:0] ALU_INPUT_SEL_IMM_B = 4'd6;
    localparam logic [ALU_INPUT_SEL_W-1:0] ALU_INPUT_SEL_IMM_J = 4'd7;
    localparam logic [ALU_INPUT_SEL_W-1:0] ALU_INPUT_SEL_FOUR  = 4'd8;

    localparam logic [1:0] ALU_MODE_ADD    = 2'd0;
    localparam logic [1:0] ALU_MODE_FUNCT  = 2'd1;
    localparam logic [1:0] ALU_MODE_BRANCH = 2'd2;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_TARGET = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU_OUT = 2'd0;
    localparam logic [1:0] WB_SEL_ALU     = 2'd1;
    localparam logic [1:0] WB_SEL_MDR     = 2'd2;

    typedef enum logic [3:0] {
        CLS_OP, CLS_OP_IMM, CLS_LUI, CLS_AUIPC, CLS_LOAD, CLS_STORE,
        CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_SYSTEM, CLS_ILLEGAL
    } insn_cls_t;
endpackage

// File: rtl/core_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath/memory side (slave).
interface core_sequencer_if;
    import core_sequencer_pkg::*;

    logic [6:0]                 opcode;
    logic                       branch_cond;
    logic                       mem_ready;
    logic                       mem_req;
    logic                       mem_we;
    logic                       addr_sel;
    logic [ALU_INPUT_SEL_W-1:0] alu_a_sel;
    logic [ALU_INPUT_SEL_W-1:0] alu_b_sel;
    logic [1:0]                 alu_mode;
    logic                       ir_we;
    logic                       pc_we;
    logic [1:0]                 pc_src;
    logic                       alu_out_we;
    logic                       mdr_we;
    logic                       rf_we;
    logic [1:0]                 wb_sel;
    logic                       halted;
    logic                       illegal;

    modport master (
        input  opcode, branch_cond, mem_ready,
        output mem_req, mem_we, addr_sel, alu_a_sel, alu_b_sel, alu_mode,
               ir_we, pc_we, pc_src, alu_out_we, mdr_we, rf_we, wb_sel,
               halted, illegal
    );

    modport slave (
        output opcode, branch_cond, mem_ready,
        input  mem_req, mem_we, addr_sel, alu_a_sel, alu_b_sel, alu_mode,
               ir_we, pc_we, pc_src, alu_out_we, mdr_we, rf_we, wb_sel,
               halted, illegal
    );
endinterface

// File: rtl/core_sequencer_decode.sv
// Opcode to instruction class; anything outside the RV32I base set is illegal.
module core_sequencer_decode
    import core_sequencer_pkg::*;
(
    input  logic [6:0] i_opcode,
    output insn_cls_t  o_cls,
    output logic       o_illegal
);
    always_comb begin
        o_cls = CLS_ILLEGAL;
        case (i_opcode)
            OPCODE_OP:     o_cls = CLS_OP;
            OPCODE_OP_IMM: o_cls = CLS_OP_IMM;
            OPCODE_LUI:    o_cls = CLS_LUI;
            OPCODE_AUIPC:  o_cls = CLS_AUIPC;
            OPCODE_LOAD:   o_cls = CLS_LOAD;
            OPCODE_STORE:  o_cls = CLS_STORE;
            OPCODE_BRANCH: o_cls = CLS_BRANCH;
            OPCODE_JAL:    o_cls = CLS_JAL;
            OPCODE_JALR:   o_cls = CLS_JALR;
            OPCODE_SYSTEM: o_cls = CLS_SYSTEM;
            default:       o_cls = CLS_ILLEGAL;
        endcase
        o_illegal = (o_cls == CLS_ILLEGAL);
    end
endmodule

// File: rtl/core_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WB control FSM for mincore; outputs are a
// combinational decode of the state register and the current opcode.
module core_sequencer
    import core_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    core_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WB, ST_HALT
    } state_t;

    state_t    r_state, w_next;
    logic      r_illegal, w_set_illegal;
    insn_cls_t w_cls;
    logic      w_cls_illegal;

    core_sequencer_decode u_decode (
        .i_opcode  (bus.opcode),
        .o_cls     (w_cls),
        .o_illegal (w_cls_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_set_illegal  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.addr_sel   = 1'b0;
        bus.alu_a_sel  = ALU_INPUT_SEL_ZERO;
        bus.alu_b_sel  = ALU_INPUT_SEL_ZERO;
        bus.alu_mode   = ALU_MODE_ADD;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = PC_SRC_ALU;
        bus.alu_out_we = 1'b0;
        bus.mdr_we     = 1'b0;
        bus.rf_we      = 1'b0;
        bus.wb_sel     = WB_SEL_ALU_OUT;
        bus.halted     = 1'b0;
        bus.illegal    = r_illegal & ~rst;
        // Reset overrides the state decode so an in-flight request drops immediately.
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.alu_a_sel = ALU_INPUT_SEL_PC;
                    bus.alu_b_sel = ALU_INPUT_SEL_FOUR;
                    if (bus.mem_ready) begin
                        bus.ir_we = 1'b1;
                        bus.pc_we = 1'b1;
                        w_next    = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    w_next = ST_EXECUTE;
                    case (w_cls)
                        CLS_BRANCH: begin
                            bus.alu_a_sel  = ALU_INPUT_SEL_PC;
                            bus.alu_b_sel  = ALU_INPUT_SEL_IMM_B;
                            bus.alu_out_we = 1'b1;
                        end
                        CLS_JAL: begin
                            bus.alu_a_sel  = ALU_INPUT_SEL_PC;
                            bus.alu_b_sel  = ALU_INPUT_SEL_IMM_J;
                            bus.alu_out_we = 1'b1;
                        end
                        CLS_SYSTEM: w_next = ST_HALT;
                        default: begin
                            if (w_cls_illegal) begin
                                w_next        = ST_HALT;
                                w_set_illegal = 1'b1;
                            end
                        end
                    endcase
                end
                ST_EXECUTE: begin
                    w_next = ST_WB;
                    case (w_cls)
                        CLS_OP: begin
                            bus.alu_a_sel  = ALU_INPUT_SEL_REG;
                            bus.alu_b_sel  = ALU_INPUT_SEL_REG;
                            bus.alu_mode   = ALU_MODE_FUNCT;
                            bus.alu_out_we = 1'b1;
                        end
                        CLS_OP_IMM: begin
                            bus.alu_a_sel  = ALU_INPUT_SEL_REG;
                            bus.alu_b_sel  = ALU_INPUT_SEL_IMM_I;
                            bus.alu_mode   = ALU_MODE_FUNCT;
                            bus.alu_out_we = 1'b1;
                        end
                        CLS_LUI: begin
                            bus.alu_b_sel  = ALU_INPUT_SEL_IMM_U;
                            bus.alu_out_we = 1'b1;
                        end
                        CLS_AUIPC: begin
                            bus.alu_a_sel  = ALU_INPUT_SEL_PC;
                            bus.alu_b_sel  = ALU_INPUT_SEL_IMM_U;
                            bus.alu_out_we = 1'b1;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            bus.alu_a_sel  = ALU_INPUT_SEL_REG;
                            bus.alu_b_sel  = (w_cls == CLS_LOAD) ? ALU_INPUT_SEL_IMM_I
                                                                 : ALU_INPUT_SEL_IMM_S;
                            bus.alu_out_we = 1'b1;
                            w_next         = ST_MEM;
                        end
                        CLS_BRANCH: begin
                            bus.alu_a_sel = ALU_INPUT_SEL_REG;
                            bus.alu_b_sel = ALU_INPUT_SEL_REG;
                            bus.alu_mode  = ALU_MODE_BRANCH;
                            bus.pc_we     = bus.branch_cond;
                            bus.pc_src    = PC_SRC_TARGET;
                            w_next        = ST_FETCH;
                        end
                        CLS_JAL: begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = PC_SRC_TARGET;
                        end
                        CLS_JALR: begin
                            bus.alu_a_sel = ALU_INPUT_SEL_REG;
                            bus.alu_b_sel = ALU_INPUT_SEL_IMM_I;
                            bus.pc_we     = 1'b1;
                            bus.pc_src    = PC_SRC_JALR;
                        end
                        default: w_next = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    bus.mem_req  = 1'b1;
                    bus.addr_sel = 1'b1;
                    bus.mem_we   = (w_cls == CLS_STORE);
                    if (bus.mem_ready) begin
                        if (w_cls == CLS_LOAD) begin
                            bus.mdr_we = 1'b1;
                            w_next     = ST_WB;
                        end else begin
                            w_next = ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    bus.rf_we = 1'b1;
                    w_next    = ST_FETCH;
                    case (w_cls)
                        CLS_LOAD: bus.wb_sel = WB_SEL_MDR;
                        CLS_JAL, CLS_JALR: begin
                            bus.alu_a_sel = ALU_INPUT_SEL_PC;
                            bus.alu_b_sel = ALU_INPUT_SEL_FOUR;
                            bus.wb_sel    = WB_SEL_ALU;
                        end
                        default: bus.wb_sel = WB_SEL_ALU_OUT;
                    endcase
                end
                ST_HALT: bus.halted = 1'b1;
                default: w_next = ST_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: table of instructions with expected per-instruction
// summaries queued as a scoreboard, plus reset/halt sequences.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    typedef struct {
        int         cyc, nreq, nmdr, nrf, npc;
        logic       we;
        logic [3:0] dec_b;
        logic       dec_aow;
        logic [3:0] ex_a, ex_b;
        logic [1:0] ex_mode;
        logic       ex_aow, ex_pcwe;
        logic [1:0] ex_pcsrc, last_wb;
        logic [3:0] last_a, last_b;
    } exp_t;

    typedef struct {
        logic [6:0] op;
        logic       cond;
        int         wait_n;
        exp_t       e;
    } vec_t;

    localparam logic [3:0] Z  = ALU_INPUT_SEL_ZERO,  R  = ALU_INPUT_SEL_REG;
    localparam logic [3:0] PC = ALU_INPUT_SEL_PC,    II = ALU_INPUT_SEL_IMM_I;
    localparam logic [3:0] IU = ALU_INPUT_SEL_IMM_U, IS = ALU_INPUT_SEL_IMM_S;
    localparam logic [3:0] IB = ALU_INPUT_SEL_IMM_B, IJ = ALU_INPUT_SEL_IMM_J;
    localparam logic [3:0] F4 = ALU_INPUT_SEL_FOUR;
    localparam logic [1:0] AD = ALU_MODE_ADD, FN = ALU_MODE_FUNCT, BR = ALU_MODE_BRANCH;
    localparam logic [1:0] PA = PC_SRC_ALU, PT = PC_SRC_TARGET, PJ = PC_SRC_JALR;
    localparam logic [1:0] WO = WB_SEL_ALU_OUT, WA = WB_SEL_ALU, WM = WB_SEL_MDR;
    localparam int NV = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[NV];
    exp_t sb[$];

    core_sequencer_if bus();
    core_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int strobes();
        return int'(bus.ir_we | bus.pc_we | bus.alu_out_we | bus.mdr_we |
                    bus.rf_we | bus.mem_req | bus.mem_we);
    endfunction

    task automatic compare_rec(input int i, input exp_t o, input exp_t e);
        string p;
        p = $sformatf("v%0d", i);
        chk({p, ".cycles"},   o.cyc,      e.cyc);
        chk({p, ".mem_req"},  o.nreq,     e.nreq);
        chk({p, ".mdr_we"},   o.nmdr,     e.nmdr);
        chk({p, ".rf_we"},    o.nrf,      e.nrf);
        chk({p, ".pc_we"},    o.npc,      e.npc);
        chk({p, ".mem_we"},   o.we,       e.we);
        chk({p, ".dec_b"},    o.dec_b,    e.dec_b);
        chk({p, ".dec_aow"},  o.dec_aow,  e.dec_aow);
        chk({p, ".ex_a"},     o.ex_a,     e.ex_a);
        chk({p, ".ex_b"},     o.ex_b,     e.ex_b);
        chk({p, ".ex_mode"},  o.ex_mode,  e.ex_mode);
        chk({p, ".ex_aow"},   o.ex_aow,   e.ex_aow);
        chk({p, ".ex_pcwe"},  o.ex_pcwe,  e.ex_pcwe);
        chk({p, ".ex_pcsrc"}, o.ex_pcsrc, e.ex_pcsrc);
        chk({p, ".last_wb"},  o.last_wb,  e.last_wb);
        chk({p, ".last_a"},   o.last_a,   e.last_a);
        chk({p, ".last_b"},   o.last_b,   e.last_b);
    endtask

    // Entered just after a negedge with the DUT in FETCH; returns at the next FETCH.
    task automatic run_vec(input int i);
        exp_t o;
        int   k, mw;
        bit   done;
        vec_t v;
        v = vecs[i];
        sb.push_back(v.e);
        bus.opcode      = v.op;
        bus.branch_cond = v.cond;
        o = '{default: 0};
        k = 0; mw = 0; done = 0;
        while (!done) begin
            if (k > 0 && bus.mem_req && !bus.addr_sel) begin
                done = 1;
            end else if (k >= 40) begin
                n_cmp++; n_bad++;
                $display("FAIL v%0d.timeout: got %0d cycles want %0d", i, k, v.e.cyc);
                done = 1;
            end else begin
                if (bus.mem_req && bus.addr_sel) begin
                    bus.mem_ready = (mw == v.wait_n);
                    mw++;
                end else begin
                    bus.mem_ready = 1'b1;
                end
                #1;
                o.nreq += int'(bus.mem_req);
                o.nmdr += int'(bus.mdr_we);
                o.nrf  += int'(bus.rf_we);
                o.npc  += int'(bus.pc_we);
                o.we    = o.we | bus.mem_we;
                if (k == 1) begin
                    o.dec_b   = bus.alu_b_sel;
                    o.dec_aow = bus.alu_out_we;
                end
                if (k == 2) begin
                    o.ex_a     = bus.alu_a_sel;
                    o.ex_b     = bus.alu_b_sel;
                    o.ex_mode  = bus.alu_mode;
                    o.ex_aow   = bus.alu_out_we;
                    o.ex_pcwe  = bus.pc_we;
                    o.ex_pcsrc = bus.pc_src;
                end
                o.last_wb = bus.wb_sel;
                o.last_a  = bus.alu_a_sel;
                o.last_b  = bus.alu_b_sel;
                k++;
                @(negedge clk);
            end
        end
        o.cyc = k;
        compare_rec(i, o, sb.pop_front());
    endtask

    initial begin
        int bad;
        vecs[0]  = '{OPCODE_OP_IMM, 1'b0, 0, '{4, 1, 0, 1, 1, 1'b0, Z,  1'b0, R,  II, FN, 1'b1, 1'b0, PA, WO, Z,  Z }};
        vecs[1]  = '{OPCODE_OP,     1'b0, 0, '{4, 1, 0, 1, 1, 1'b0, Z,  1'b0, R,  R,  FN, 1'b1, 1'b0, PA, WO, Z,  Z }};
        vecs[2]  = '{OPCODE_LUI,    1'b0, 0, '{4, 1, 0, 1, 1, 1'b0, Z,  1'b0, Z,  IU, AD, 1'b1, 1'b0, PA, WO, Z,  Z }};
        vecs[3]  = '{OPCODE_AUIPC,  1'b0, 0, '{4, 1, 0, 1, 1, 1'b0, Z,  1'b0, PC, IU, AD, 1'b1, 1'b0, PA, WO, Z,  Z }};
        vecs[4]  = '{OPCODE_LOAD,   1'b0, 0, '{5, 2, 1, 1, 1, 1'b0, Z,  1'b0, R,  II, AD, 1'b1, 1'b0, PA, WM, Z,  Z }};
        vecs[5]  = '{OPCODE_LOAD,   1'b0, 3, '{8, 5, 1, 1, 1, 1'b0, Z,  1'b0, R,  II, AD, 1'b1, 1'b0, PA, WM, Z,  Z }};
        vecs[6]  = '{OPCODE_STORE,  1'b0, 0, '{4, 2, 0, 0, 1, 1'b1, Z,  1'b0, R,  IS, AD, 1'b1, 1'b0, PA, WO, Z,  Z }};
        vecs[7]  = '{OPCODE_STORE,  1'b0, 2, '{6, 4, 0, 0, 1, 1'b1, Z,  1'b0, R,  IS, AD, 1'b1, 1'b0, PA, WO, Z,  Z }};
        vecs[8]  = '{OPCODE_BRANCH, 1'b1, 0, '{3, 1, 0, 0, 2, 1'b0, IB, 1'b1, R,  R,  BR, 1'b0, 1'b1, PT, WO, R,  R }};
        vecs[9]  = '{OPCODE_BRANCH, 1'b0, 0, '{3, 1, 0, 0, 1, 1'b0, IB, 1'b1, R,  R,  BR, 1'b0, 1'b0, PT, WO, R,  R }};
        vecs[10] = '{OPCODE_JAL,    1'b0, 0, '{4, 1, 0, 1, 2, 1'b0, IJ, 1'b1, Z,  Z,  AD, 1'b0, 1'b1, PT, WA, PC, F4}};
        vecs[11] = '{OPCODE_JALR,   1'b0, 0, '{4, 1, 0, 1, 2, 1'b0, Z,  1'b0, R,  II, AD, 1'b0, 1'b1, PJ, WA, PC, F4}};

        bus.opcode      = OPCODE_OP_IMM;
        bus.branch_cond = 1'b0;
        bus.mem_ready   = 1'b1;

        // Reset held: everything quiet, selectors ZERO/ZERO.
        @(negedge clk);
        chk("rst.strobes", strobes(), 0);
        chk("rst.halted", bus.halted, 0);
        chk("rst.illegal", bus.illegal, 0);
        chk("rst.a_sel", bus.alu_a_sel, Z);
        chk("rst.b_sel", bus.alu_b_sel, Z);

        // FETCH waiting on memory holds its request; reset mid-wait drops it at once.
        bus.mem_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("fetch.mem_req", bus.mem_req, 1);
        chk("fetch.a_sel", bus.alu_a_sel, PC);
        chk("fetch.b_sel", bus.alu_b_sel, F4);
        chk("fetch.ir_we", bus.ir_we, 0);
        @(negedge clk); #1;
        chk("fetch_wait.mem_req", bus.mem_req, 1);
        chk("fetch_wait.addr_sel", bus.addr_sel, 0);
        chk("fetch_wait.pc_we", bus.pc_we, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async.mem_req", bus.mem_req, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release.mem_req", bus.mem_req, 1);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Unknown opcode: HALT with illegal, sticky and silent until reset.
        bus.opcode    = 7'b1111111;
        bus.mem_ready = 1'b1;
        #1;
        chk("ill.fetch_ir_we", bus.ir_we, 1);
        @(negedge clk); #1;
        chk("ill.decode_halted", bus.halted, 0);
        @(negedge clk); #1;
        chk("ill.halted", bus.halted, 1);
        chk("ill.illegal", bus.illegal, 1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (strobes() != 0 || !bus.halted || !bus.illegal) bad++;
        end
        chk("ill.sticky_quiet_cycles", bad, 0);
        rst = 1'b1;
        #1;
        chk("ill.rst_halted", bus.halted, 0);
        chk("ill.rst_illegal", bus.illegal, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ill.restart_mem_req", bus.mem_req, 1);
        chk("ill.restart_illegal", bus.illegal, 0);

        // SYSTEM halts without flagging illegal.
        bus.opcode = OPCODE_SYSTEM;
        @(negedge clk);
        @(negedge clk); #1;
        chk("sys.halted", bus.halted, 1);
        chk("sys.illegal", bus.illegal, 0);
        chk("sys.strobes", strobes(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multicycle control FSM for mincore. It sequences one RV32I instruction at a time through fetch, decode, execute, memory and writeback. It drives both ALU operand selectors (`alu_input_sel` encodings from `alu.vh`), the ALU operation mode, and all datapath write strobes. It also runs the request/ready handshake to instruction/data memory. It sits between the instruction register and the datapath (register file, PC, ALU operand muxes, ALU output latch, memory data register).

## Interface
Parameters: none; all widths come from `alu.vh`, `instruction.vh` and `register.vh`.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  7  `ir[6:0]`; valid from DECODE onward
- `branch_cond`  in  1  ALU compare result for the current funct3
- `mem_ready`  in  1  memory accepted write / returned read data this cycle
- `mem_req`  out  1  memory request
- `mem_we`  out  1  write (store) when `mem_req`=1
- `addr_sel`  out  1  0 = PC, 1 = ALU output latch
- `alu_a_sel`  out  `ALU_INPUT_SEL_W`  operand A select
- `alu_b_sel`  out  `ALU_INPUT_SEL_W`  operand B select
- `alu_mode`  out  2  ADD / FUNCT (funct3/funct7 decode) / BRANCH (compare)
- `ir_we`  out  1  load IR; the datapath also latches the instruction PC (`PC` selector = instruction PC)
- `pc_we`  out  1  PC write
- `pc_src`  out  2  ALU / TARGET (ALU output latch) / JALR (ALU result & ~1)
- `alu_out_we`  out  1  latch ALU result
- `mdr_we`  out  1  latch read data
- `rf_we`  out  1  register-file write
- `wb_sel`  out  2  ALU_OUT latch / ALU live / MDR
- `halted`  out  1  core stopped
- `illegal`  out  1  stop caused by an unknown opcode

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT. Reset state is FETCH.
- FETCH:
  - Outputs: `mem_req`=1, `addr_sel`=PC, A=PC, B=FOUR, mode ADD.
  - On `mem_ready`: `ir_we`=1, `pc_we`=1 (`pc_src` ALU), go to DECODE.
  - Otherwise hold all outputs stable.
- DECODE:
  - BRANCH: A=PC, B=IMM_B, ADD, `alu_out_we`=1 (target).
  - JAL: A=PC, B=IMM_J, ADD, `alu_out_we`=1 (target).
  - SYSTEM (1110011): go to HALT.
  - Any opcode not listed below: go to HALT with `illegal` set.
  - All other listed opcodes: go to EXECUTE.
- EXECUTE:
  - OP: A=REG, B=REG, FUNCT, `alu_out_we`; go to WB.
  - OP-IMM: A=REG, B=IMM_I, FUNCT, `alu_out_we`; go to WB.
  - LUI: A=ZERO, B=IMM_U, ADD, `alu_out_we`; go to WB.
  - AUIPC: A=PC, B=IMM_U, ADD, `alu_out_we`; go to WB.
  - LOAD: A=REG, B=IMM_I, ADD, `alu_out_we`; go to MEM.
  - STORE: A=REG, B=IMM_S, ADD, `alu_out_we`; go to MEM.
  - BRANCH: A=REG, B=REG, mode BRANCH, `alu_out_we`=0. `pc_we`=`branch_cond` with `pc_src` TARGET. Go to FETCH.
  - JAL: `pc_we`=1, `pc_src` TARGET; go to WB.
  - JALR: A=REG, B=IMM_I, ADD, `pc_we`=1, `pc_src` JALR; go to WB.
- MEM:
  - Outputs: `mem_req`=1, `addr_sel`=ALU_OUT, `mem_we`=1 for STORE.
  - On `mem_ready`, LOAD: `mdr_we`=1, go to WB.
  - On `mem_ready`, STORE: go to FETCH.
- WB:
  - LOAD: `rf_we`=1, `wb_sel` MDR.
  - JAL/JALR: A=PC, B=FOUR, ADD, `wb_sel` ALU live.
  - Others: `wb_sel` ALU_OUT.
  - Always go to FETCH.
- HALT:
  - All strobes 0, `halted`=1, `illegal` as latched. Sticky until `rst`.
- Default selectors whenever unused: A=ZERO, B=ZERO, mode ADD.

## Timing
- Outputs are a combinational decode of the state register and `opcode`. They carry no additional register stage.
- While `rst`=1: state=FETCH; all strobes, `mem_req`, `halted` and `illegal` are 0; selectors are ZERO/ZERO.
- With zero-wait memory (`mem_ready` high in the same cycle as the request):
  - BRANCH: 3 cycles.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1 cycle.
- Handshake:
  - `mem_req`, `mem_we` and `addr_sel` stay stable until the cycle with `mem_ready`=1; transfer completes in that cycle.
  - `mem_ready` is ignored when `mem_req`=0.
- A `rst` assertion mid-request drops `mem_req` at once. Memory must tolerate an abandoned request.
- `illegal` is set only on the DECODE→HALT transition.

## Structure
- Add to `alu.vh`:
  - `ALU_INPUT_SEL_IMM_S`, `_IMM_B`, `_IMM_J`, `_FOUR`.
  - `ALU_MODE_*`.
- Extend `alu_input_mux` to decode the new selector encodings.
- Add to `instruction.vh`: `OPCODE_*` constants, `PC_SRC_*`, `WB_SEL_*`.
- State encoding stays local to the module.
- Optional sub-module `opcode_class_decode`: opcode to instruction class plus illegal flag.

## Test plan
- ADDI x1,x0,5 with zero-wait memory → FETCH, DECODE, EXECUTE (A=REG, B=IMM_I, FUNCT), WB `rf_we`=1; `mem_req` high 1 cycle; 4 cycles total.
- LW with `mem_ready` delayed 3 cycles in MEM → `mem_req`/`addr_sel`=1 held 4 cycles; `mdr_we` pulses once; WB `wb_sel` MDR; 8 cycles total.
- BEQ, run twice: `branch_cond`=1 → `pc_we`=1 with `pc_src` TARGET in EXECUTE. `branch_cond`=0 → no `pc_we` in EXECUTE. Both cases take 3 cycles with no `rf_we`.
- JALR → EXECUTE `pc_we` with `pc_src` JALR; WB A=PC, B=FOUR, `wb_sel` ALU live, `rf_we`=1.
- `opcode`=7'b1111111 → HALT after DECODE with `halted`=1 and `illegal`=1. All strobes stay 0 for ≥10 cycles. `rst` pulse returns to FETCH with both flags 0.
- `rst` asserted during a FETCH wait → `mem_req` drops asynchronously. After release, FETCH restarts with `mem_req`=1.
